byte_assembler: RTL and testbench
=================================

BYTE_ASSEMBLER -- requirements
Module: byte_assembler

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the RAM write address.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port byte_in, input, 8, the data byte presented with byte_valid.
REQ-005 SHALL have port byte_valid, input, 1, single-cycle strobe: byte_in is valid this cycle.
REQ-006 SHALL have port clear, input, 1, synchronous abort: discard any partial word and return to the high-byte phase.
REQ-007 SHALL have port ready, output, 1, high when a byte can be accepted this cycle.
REQ-008 SHALL have port phase, output, 1, 0 = expecting the high byte, 1 = expecting the low byte.
REQ-009 SHALL have port word_out, output, 16, the assembled word {hi, lo}.
REQ-010 SHALL have port we, output, 1, single-cycle RAM write strobe.
REQ-011 SHALL have port addr, output, ADDR_W, the RAM write address.
REQ-012 SHALL have port wrap, output, 1, single-cycle pulse when addr rolls over from all-ones to 0.

Function
REQ-013 SHALL implement three states: WAIT_HI, WAIT_LO, WRITE.
REQ-014 SHALL accept a byte only in a cycle where byte_valid=1, ready=1 and clear=0.
REQ-015 In WAIT_HI, on an accepted byte, SHALL latch it into the high register, enter WAIT_LO, and show phase=1 on the next cycle.
REQ-016 In WAIT_LO, on an accepted byte, SHALL latch it into the low register and enter WRITE.
REQ-017 In WRITE, SHALL assert we=1 for exactly one cycle, with word_out={hi,lo} and addr equal to the pre-increment address.
REQ-018 On leaving WRITE, SHALL return to WAIT_HI and increment addr by 1 modulo 2^ADDR_W; addr shows the new value on the cycle after we.
REQ-019 SHALL hold ready=1 in WAIT_HI and WAIT_LO, and ready=0 in WRITE; byte_valid in WRITE SHALL be ignored and dropped.
REQ-020 Latency SHALL be one cycle from the accepted low byte to we=1.
REQ-021 SHALL pulse wrap=1 in the same cycle the address increments from 2^ADDR_W-1 to 0.
REQ-022 clear SHALL take priority over byte_valid.
REQ-023 clear in WAIT_LO SHALL discard the high byte and enter WAIT_HI.
REQ-024 clear in WRITE SHALL still complete the write, with addr still incrementing.
REQ-025 clear SHALL never modify addr.
REQ-026 SHALL hold word_out stable outside WRITE at the last assembled value.
REQ-027 phase SHALL be 1 exactly when in WAIT_LO, so that it can drive a downstream hi/lo byte selector directly.

Reset
REQ-028 While reset_n=0, SHALL force: state WAIT_HI, phase=0, ready=1, we=0, wrap=0, word_out=16'h0000, addr=0, hi and lo registers = 8'h00.
REQ-029 Reset asserted mid-word or during WRITE SHALL take effect immediately without clock; the partial word SHALL be lost and no we is issued.

Structure
REQ-030 SHALL place the state encoding constants (WAIT_HI=2'b00, WAIT_LO=2'b01, WRITE=2'b10) and the ADDR_W default in shared package byte_pkg.
REQ-031 SHALL implement the address register and wrap detection as sub-module addr_counter (inputs clk, reset_n, inc; outputs addr, wrap).
REQ-032 An unused state encoding (2'b11) SHALL recover to WAIT_HI on the next clock.

Verification
REQ-033 Bytes 8'hAB then 8'hCD, each with one strobe, from reset -> exactly one cycle of we=1 with word_out=16'hABCD, addr=0; addr=1 the following cycle.
REQ-034 Strobe 8'h12, then clear, then strobes 8'h34 and 8'h56 -> single write of 16'h3456 at addr 0; phase=0 right after clear.
REQ-035 byte_valid held high for 4 consecutive cycles with 8'h11, 8'h22, 8'h33, 8'h44 -> first write is 16'h1122; 8'h33 is dropped (ready=0 in WRITE); second word begins with 8'h44.
REQ-036 ADDR_W=2, 4 complete words -> addr sequence 0,1,2,3 on the writes; wrap=1 in the cycle addr returns to 0.
REQ-037 reset_n pulled low asynchronously between the high and low bytes -> outputs immediately at reset values; no we; next two bytes write to addr 0.
REQ-038 clear asserted in the WRITE cycle of 16'hBEEF -> we=1 with 16'hBEEF still issued, addr increments, and the next state is WAIT_HI.

Source files
------------

// File: rtl/byte_pkg.sv
// Shared definitions for the byte-to-word assembler: state encoding,
// default write-address width and the byte acceptance rule.
package byte_pkg;

   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      WAIT_HI = 2'b00,
      WAIT_LO = 2'b01,
      WRITE   = 2'b10
   } state_e;

   // A byte is taken only when offered, accepted and not overridden by clear.
   function automatic logic byte_accept(input logic valid, input logic rdy, input logic clr);
      return valid & rdy & ~clr;
   endfunction

endpackage

// File: rtl/addr_counter.sv
// RAM write-address register. Advances by one on inc, wrapping modulo 2^W,
// and flags the all-ones -> zero rollover with a one-cycle wrap pulse that
// lines up with the cycle the address first reads zero.
module addr_counter
   import byte_pkg::*;
#(
   parameter int W = ADDR_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] addr,
   output logic         wrap
);

   logic [W-1:0] addr_q;
   logic [W-1:0] addr_d;
   logic         wrap_q;
   logic         wrap_d;

   // Next address and rollover detection.
   always_comb begin
      addr_d = addr_q;
      wrap_d = 1'b0;
      if (inc) begin
         addr_d = addr_q + W'(1);
         wrap_d = (addr_q == {W{1'b1}});
      end
   end

   // Address and wrap pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wrap_q <= wrap_d;
      end
   end

   assign addr = addr_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/byte_assembler.sv
// Collects a high byte then a low byte into a 16-bit word and writes it to
// a RAM through a one-cycle write strobe at an auto-incrementing address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT_HI | idle / expecting the high byte, phase=0, ready=1
// WAIT_LO | high byte held, expecting the low byte, phase=1, ready=1
// WRITE   | we=1 with the assembled word, ready=0, incoming bytes dropped
//
// All FSM outputs are registered and updated together with the state, so
// phase is exactly "in WAIT_LO" and can drive a hi/lo selector directly.
module byte_assembler
   import byte_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   input  logic              clear,
   output logic              ready,
   output logic              phase,
   output logic [15:0]       word_out,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic              wrap
);

   state_e     state_q;
   logic [7:0] hi_q;
   logic [7:0] lo_q;
   logic [7:0] word_hi_q;
   logic       ready_q;
   logic       phase_q;
   logic       we_q;
   logic       accept;
   logic       inc;

   assign accept = byte_accept(byte_valid, ready_q, clear);

   // The address moves on the clock edge that leaves WRITE; clear is not
   // looked at here, so an abort never touches the address.
   assign inc = (state_q == WRITE);

   // Sequencing FSM with registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= WAIT_HI;
         hi_q      <= 8'h00;
         lo_q      <= 8'h00;
         word_hi_q <= 8'h00;
         ready_q   <= 1'b1;
         phase_q   <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            WAIT_HI: begin
               if (accept) begin
                  hi_q    <= byte_in;
                  state_q <= WAIT_LO;
                  phase_q <= 1'b1;
               end
            end
            WAIT_LO: begin
               if (clear) begin
                  // The held high byte is abandoned; it is overwritten by
                  // the next accepted high byte before it can be used.
                  state_q <= WAIT_HI;
                  phase_q <= 1'b0;
               end else if (accept) begin
                  lo_q      <= byte_in;
                  word_hi_q <= hi_q;
                  state_q   <= WRITE;
                  phase_q   <= 1'b0;
                  ready_q   <= 1'b0;
                  we_q      <= 1'b1;
               end
            end
            WRITE: begin
               // The write is already on the bus this cycle, so clear has
               // nothing left to abort and the FSM simply returns.
               state_q <= WAIT_HI;
               phase_q <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= WAIT_HI;
               phase_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   addr_counter #(
      .W (ADDR_W)
   ) u_addr_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc),
      .addr    (addr),
      .wrap    (wrap)
   );

   // word_out is built from registers that only load on entry to WRITE, so
   // it holds the last assembled word while new bytes are being collected.
   assign word_out = {word_hi_q, lo_q};
   assign ready    = ready_q;
   assign phase    = phase_q;
   assign we       = we_q;

endmodule

// File: tb/tb_byte_assembler.sv
// Directed bench: two instances (default width and 2-bit address) share
// one stimulus stream; a vector table covers normal operation, clear and
// wrap, and hand-written sequences cover asynchronous reset.
module tb_byte_assembler;

   logic        clk;
   logic        reset_n;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        clear;

   logic        ready8, phase8, we8, wrap8;
   logic [15:0] word8;
   logic [7:0]  addr8;
   logic        ready2, phase2, we2, wrap2;
   logic [15:0] word2;
   logic [1:0]  addr2;

   int checks;
   int errors;

   byte_assembler u_dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .clear      (clear),
      .ready      (ready8),
      .phase      (phase8),
      .word_out   (word8),
      .we         (we8),
      .addr       (addr8),
      .wrap       (wrap8)
   );

   byte_assembler #(.ADDR_W(2)) u_dut2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .clear      (clear),
      .ready      (ready2),
      .phase      (phase2),
      .word_out   (word2),
      .we         (we2),
      .addr       (addr2),
      .wrap       (wrap2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic        clr;
      logic        rdy;
      logic        ph;
      logic        we;
      logic [15:0] word;
      logic [7:0]  a8;
      logic [1:0]  a2;
      logic        w8;
      logic        w2;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] b, input logic c);
      byte_valid = v;
      byte_in    = b;
      clear      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " ready"},  {15'd0, ready8}, 16'd1);
      chk({tag, " phase"},  {15'd0, phase8}, 16'd0);
      chk({tag, " we"},     {15'd0, we8},    16'd0);
      chk({tag, " wrap"},   {15'd0, wrap8},  16'd0);
      chk({tag, " word"},   word8,           16'h0000);
      chk({tag, " addr8"},  {8'd0, addr8},   16'd0);
      chk({tag, " addr2"},  {14'd0, addr2},  16'd0);
      chk({tag, " we2"},    {15'd0, we2},    16'd0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      clear      = 1'b0;

      //            v     b      clr   rdy   ph    we    word      a8     a2    w8    w2
      tbl.push_back('{1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 8'd0, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 8'd1, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD, 8'd1, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'hABCD, 8'd1, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD, 8'd1, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3456, 8'd1, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3456, 8'd2, 2'd2, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3456, 8'd2, 2'd2, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1122, 8'd2, 2'd2, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1122, 8'd3, 2'd3, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1122, 8'd3, 2'd3, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4455, 8'd3, 2'd3, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'hBE, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4455, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 8'd4, 2'd0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 8'd5, 2'd1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 8'd5, 2'd1, 1'b0, 1'b0});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reset("por");
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].b, tbl[i].clr);
         chk($sformatf("v%0d ready", i), {15'd0, ready8}, {15'd0, tbl[i].rdy});
         chk($sformatf("v%0d phase", i), {15'd0, phase8}, {15'd0, tbl[i].ph});
         chk($sformatf("v%0d we", i),    {15'd0, we8},    {15'd0, tbl[i].we});
         chk($sformatf("v%0d word", i),  word8,           tbl[i].word);
         chk($sformatf("v%0d addr8", i), {8'd0, addr8},   {8'd0, tbl[i].a8});
         chk($sformatf("v%0d wrap8", i), {15'd0, wrap8},  {15'd0, tbl[i].w8});
         chk($sformatf("v%0d we2", i),   {15'd0, we2},    {15'd0, tbl[i].we});
         chk($sformatf("v%0d word2", i), word2,           tbl[i].word);
         chk($sformatf("v%0d addr2", i), {14'd0, addr2},  {14'd0, tbl[i].a2});
         chk($sformatf("v%0d wrap2", i), {15'd0, wrap2},  {15'd0, tbl[i].w2});
      end

      // asynchronous reset between high and low byte
      step(1'b1, 8'h12, 1'b0);
      chk("midword phase", {15'd0, phase8}, 16'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset("async midword");
      step(1'b1, 8'h34, 1'b0);
      chk_reset("held reset");
      reset_n = 1'b1;
      step(1'b1, 8'h5A, 1'b0);
      chk("post-reset phase", {15'd0, phase8}, 16'd1);
      step(1'b1, 8'h5B, 1'b0);
      chk("post-reset we",    {15'd0, we8},   16'd1);
      chk("post-reset word",  word8,          16'h5A5B);
      chk("post-reset addr8", {8'd0, addr8},  16'd0);
      chk("post-reset addr2", {14'd0, addr2}, 16'd0);

      // asynchronous reset in the WRITE cycle: strobe vanishes, no increment
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset("async write");
      reset_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      chk("after write reset addr8", {8'd0, addr8}, 16'd0);
      chk("after write reset we",    {15'd0, we8},  16'd0);
      chk("after write reset phase", {15'd0, phase8}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
